// File: rtl/exec_core_pkg.sv
// Shared encodings for exec_core: opcodes, FSM states, flag bit positions.
package exec_core_pkg;

    localparam int unsigned OPC_W  = 4;
    localparam int unsigned FLAG_W = 4;

    // Flag vector layout is {Z, N, C, V}
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_MOV = 4'd5,
        OP_NOT = 4'd6,
        OP_CMP = 4'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EX1  = 2'd1,
        ST_EX2  = 2'd2,
        ST_EX3  = 2'd3
    } state_e;

    // Encodings above OP_CMP are reserved and rejected with an error pulse
    function automatic logic is_legal(input logic [OPC_W-1:0] op);
        return (op <= 4'(OP_CMP));
    endfunction

endpackage

// File: rtl/exec_core_regfile.sv
// NREG x WIDTH register file: one write port, three combinational read ports.
module exec_core_regfile #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned NREG  = 4,
    localparam int unsigned RIDX  = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [RIDX-1:0]  widx_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [RIDX-1:0]  ra_idx_i,
    output logic [WIDTH-1:0] ra_data_o,
    input  logic [RIDX-1:0]  rb_idx_i,
    output logic [WIDTH-1:0] rb_data_o,
    input  logic [RIDX-1:0]  rc_idx_i,
    output logic [WIDTH-1:0] rc_data_o
);

    logic [WIDTH-1:0] mem_q [NREG];

    // Storage: cleared by reset, single write per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    assign ra_data_o = mem_q[ra_idx_i];
    assign rb_data_o = mem_q[rb_idx_i];
    assign rc_data_o = mem_q[rc_idx_i];

endmodule

// File: rtl/exec_core.sv
// Multi-cycle execution core: IDLE -> EX1 (fetch OP1) -> EX2 (fetch OP2) -> EX3 (ALU + writeback).
module exec_core
    import exec_core_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned NREG  = 4,
    localparam int unsigned RIDX  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [RIDX-1:0]   src,
    input  logic [RIDX-1:0]   dest,
    output logic              ready,
    output logic              done,
    output logic              error,
    output logic [WIDTH-1:0]  result,
    output logic [FLAG_W-1:0] flags,
    input  logic              wr_en,
    input  logic [RIDX-1:0]   wr_idx,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [RIDX-1:0]   rd_idx,
    output logic [WIDTH-1:0]  rd_data
);

    localparam int unsigned MSB = WIDTH - 1;

    state_e             state_q;
    opcode_e            op_q;
    logic [RIDX-1:0]    src_q;
    logic [RIDX-1:0]    dest_q;
    logic [WIDTH-1:0]   op1_q;
    logic [WIDTH-1:0]   op2_q;
    logic [WIDTH-1:0]   result_q;
    logic [FLAG_W-1:0]  flags_q;
    logic               ready_q;
    logic               done_q;
    logic               error_q;

    logic [WIDTH-1:0]   rs_data;
    logic [WIDTH-1:0]   rt_data;

    logic               rf_we;
    logic [RIDX-1:0]    rf_widx;
    logic [WIDTH-1:0]   rf_wdata;

    logic [WIDTH:0]     sum_c;
    logic [WIDTH:0]     diff_c;
    logic [WIDTH-1:0]   alu_res_c;
    logic [FLAG_W-1:0]  alu_flags_c;
    logic               alu_wr_c;

    exec_core_regfile #(
        .WIDTH (WIDTH),
        .NREG  (NREG)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .we_i      (rf_we),
        .widx_i    (rf_widx),
        .wdata_i   (rf_wdata),
        .ra_idx_i  (src_q),
        .ra_data_o (rs_data),
        .rb_idx_i  (dest_q),
        .rb_data_o (rt_data),
        .rc_idx_i  (rd_idx),
        .rc_data_o (rd_data)
    );

    // Borrow of the subtract is bit WIDTH of the zero-extended difference
    assign sum_c  = {1'b0, op2_q} + {1'b0, op1_q};
    assign diff_c = {1'b0, op2_q} - {1'b0, op1_q};

    // ALU: result, flags and whether the op writes back
    always_comb begin
        alu_res_c   = '0;
        alu_flags_c = '0;
        alu_wr_c    = 1'b1;
        case (op_q)
            OP_ADD: begin
                alu_res_c           = sum_c[WIDTH-1:0];
                alu_flags_c[FLAG_C] = sum_c[WIDTH];
                alu_flags_c[FLAG_V] = (op2_q[MSB] == op1_q[MSB]) && (alu_res_c[MSB] != op2_q[MSB]);
            end
            OP_SUB, OP_CMP: begin
                alu_res_c           = diff_c[WIDTH-1:0];
                alu_flags_c[FLAG_C] = diff_c[WIDTH];
                alu_flags_c[FLAG_V] = (op2_q[MSB] != op1_q[MSB]) && (alu_res_c[MSB] != op2_q[MSB]);
                alu_wr_c            = (op_q != OP_CMP);
            end
            OP_AND:  alu_res_c = op2_q & op1_q;
            OP_OR:   alu_res_c = op2_q | op1_q;
            OP_XOR:  alu_res_c = op2_q ^ op1_q;
            OP_MOV:  alu_res_c = op1_q;
            OP_NOT:  alu_res_c = ~op1_q;
            default: alu_wr_c  = 1'b0;
        endcase
        alu_flags_c[FLAG_Z] = (alu_res_c == '0);
        alu_flags_c[FLAG_N] = alu_res_c[MSB];
    end

    // Write port arbitration: external writes only in IDLE, ALU writeback in EX3
    always_comb begin
        rf_we    = 1'b0;
        rf_widx  = wr_idx;
        rf_wdata = wr_data;
        if (state_q == ST_IDLE) begin
            rf_we = wr_en;
        end else if ((state_q == ST_EX3) && alu_wr_c) begin
            rf_we    = 1'b1;
            rf_widx  = dest_q;
            rf_wdata = alu_res_c;
        end
    end

    // Control FSM with registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            src_q    <= '0;
            dest_q   <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (is_legal(opcode)) begin
                            op_q    <= opcode_e'(opcode);
                            src_q   <= src;
                            dest_q  <= dest;
                            ready_q <= 1'b0;
                            state_q <= ST_EX1;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                ST_EX1: begin
                    op1_q   <= rs_data;
                    state_q <= ST_EX2;
                end
                ST_EX2: begin
                    op2_q   <= rt_data;
                    state_q <= ST_EX3;
                end
                ST_EX3: begin
                    result_q <= alu_res_c;
                    flags_q  <= alu_flags_c;
                    done_q   <= 1'b1;
                    ready_q  <= 1'b1;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign error  = error_q;
    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_exec_core.sv
// Self-checking bench for exec_core (WIDTH=8, NREG=4): vector table, corner sequences, random ops vs model.
module tb_exec_core;
    import exec_core_pkg::*;

    logic       clk = 1'b0;
    logic       reset, start, wr_en;
    logic [3:0] opcode;
    logic [1:0] src, dest, wr_idx, rd_idx;
    logic [7:0] wr_data, rd_data, result;
    logic       ready, done, error;
    logic [3:0] flags;

    always #5 clk = ~clk;

    exec_core #(.WIDTH(8), .NREG(4)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .src(src), .dest(dest),
        .ready(ready), .done(done), .error(error), .result(result), .flags(flags),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .rd_idx(rd_idx), .rd_data(rd_data)
    );

    int checks = 0;
    int errors = 0;

    // Architectural model: register values, last result and last flags
    int         mdl_r [4];
    int         mdl_res;
    logic [3:0] mdl_flg;

    typedef struct {
        logic [3:0] op;
        int         s;
        int         d;
        int         vs;
        int         vd;
        int         res;
        logic [3:0] flg;
        int         rdest;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sx(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Apply an op to the model using plain integer arithmetic
    task automatic model_exec(input logic [3:0] op, input int s, input int d);
        int a, b, full, sfull, res;
        bit c, v, w;
        a = mdl_r[s]; b = mdl_r[d];
        c = 1'b0; v = 1'b0; w = 1'b1; res = 0;
        if (op == OP_ADD) begin
            full = b + a; res = full & 255; c = (full > 255);
            sfull = sx(b) + sx(a); v = (sfull > 127) || (sfull < -128);
        end else if (op == OP_SUB || op == OP_CMP) begin
            res = (b - a) & 255; c = (a > b);
            sfull = sx(b) - sx(a); v = (sfull > 127) || (sfull < -128);
            w = (op == OP_SUB);
        end else if (op == OP_AND) res = b & a;
        else if (op == OP_OR)  res = b | a;
        else if (op == OP_XOR) res = b ^ a;
        else if (op == OP_MOV) res = a;
        else if (op == OP_NOT) res = 255 - a;
        mdl_res = res;
        mdl_flg = {res == 0, res >= 128, c, v};
        if (w) mdl_r[d] = res;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mdl_r[i] = 0;
        mdl_res = 0;
        mdl_flg = 4'h0;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i);
            #1;
            check($sformatf("%s_R%0d", tag, i), 32'(rd_data), 32'(mdl_r[i]));
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_result"}, 32'(result), 32'(mdl_res));
        check({tag, "_flags"}, 32'(flags), 32'(mdl_flg));
        check_regs(tag);
    endtask

    task automatic wr(input int idx, input int val);
        wr_en = 1'b1; wr_idx = 2'(idx); wr_data = 8'(val);
        tick();
        wr_en = 1'b0;
        mdl_r[idx] = val;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    // Issue one op from IDLE; noise drives random start/wr traffic while busy
    task automatic do_op(input logic [3:0] op, input int s, input int d, input bit noise, input string tag);
        int lat;
        bit seen;
        opcode = op; src = 2'(s); dest = 2'(d); start = 1'b1;
        if (is_legal(op)) model_exec(op, s, d);
        tick();
        start = 1'b0; wr_en = 1'b0;
        if (!is_legal(op)) begin
            check({tag, "_err_pulse"}, 32'(error), 32'd1);
            check({tag, "_err_ready"}, 32'(ready), 32'd1);
            check({tag, "_err_nodone"}, 32'(done), 32'd0);
            tick();
            check({tag, "_err_clear"}, 32'(error), 32'd0);
            check_model(tag);
            return;
        end
        check({tag, "_busy"}, 32'(ready), 32'd0);
        lat = 0; seen = 1'b0;
        while (!seen && lat < 10) begin
            if (noise) begin
                start = 1'($urandom); opcode = 4'($urandom); src = 2'($urandom); dest = 2'($urandom);
                wr_en = 1'($urandom); wr_idx = 2'($urandom); wr_data = 8'($urandom);
            end
            tick();
            lat++;
            if (done) seen = 1'b1;
        end
        start = 1'b0; wr_en = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_ready_after"}, 32'(ready), 32'd1);
        check_model(tag);
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int dcount;
        bit saw_done;
        logic [3:0] seq_ops [4];

        reset = 1'b1; start = 1'b0; wr_en = 1'b0; opcode = '0; src = '0; dest = '0;
        wr_idx = '0; wr_data = '0; rd_idx = '0;
        model_reset();
        tick(); tick();
        reset = 1'b0;

        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check_model("rst");

        //             op      s  d  vs     vd     res    flg      rdest
        tbl[0]  = '{OP_ADD, 2, 1, 8'h01, 8'h7F, 8'h80, 4'b0101, 8'h80};
        tbl[1]  = '{OP_SUB, 0, 3, 8'h05, 8'h03, 8'hFE, 4'b0110, 8'hFE};
        tbl[2]  = '{OP_ADD, 0, 1, 8'h01, 8'hFF, 8'h00, 4'b1010, 8'h00};
        tbl[3]  = '{OP_SUB, 3, 2, 8'h01, 8'h80, 8'h7F, 4'b0001, 8'h7F};
        tbl[4]  = '{OP_AND, 1, 0, 8'h3C, 8'hF0, 8'h30, 4'b0000, 8'h30};
        tbl[5]  = '{OP_OR,  2, 1, 8'h80, 8'h0F, 8'h8F, 4'b0100, 8'h8F};
        tbl[6]  = '{OP_XOR, 0, 3, 8'hAA, 8'hAA, 8'h00, 4'b1000, 8'h00};
        tbl[7]  = '{OP_MOV, 1, 2, 8'h9C, 8'h11, 8'h9C, 4'b0100, 8'h9C};
        tbl[8]  = '{OP_NOT, 3, 0, 8'hFF, 8'h12, 8'h00, 4'b1000, 8'h00};
        tbl[9]  = '{OP_CMP, 2, 1, 8'h05, 8'h05, 8'h00, 4'b1000, 8'h05};
        tbl[10] = '{OP_SUB, 2, 2, 8'h5A, 8'h5A, 8'h00, 4'b1000, 8'h00};
        tbl[11] = '{OP_CMP, 0, 3, 8'h10, 8'h08, 8'hF8, 4'b0110, 8'h08};

        for (int i = 0; i < 12; i++) begin
            wr(tbl[i].s, tbl[i].vs);
            wr(tbl[i].d, tbl[i].vd);
            do_op(tbl[i].op, tbl[i].s, tbl[i].d, 1'b0, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_vres", i), 32'(result), 32'(tbl[i].res));
            check($sformatf("tbl%0d_vflg", i), 32'(flags), 32'(tbl[i].flg));
            rd_idx = 2'(tbl[i].d); #1;
            check($sformatf("tbl%0d_vdest", i), 32'(rd_data), 32'(tbl[i].rdest));
        end

        // SUB with borrow followed by CMP of a register against itself
        wr(0, 8'h05); wr(3, 8'h03);
        do_op(OP_SUB, 0, 3, 1'b0, "subcmp_sub");
        do_op(OP_CMP, 3, 3, 1'b0, "subcmp_cmp");
        check("subcmp_flags", 32'(flags), 32'h8);
        rd_idx = 2'd3; #1;
        check("subcmp_r3_kept", 32'(rd_data), 32'hFE);

        // External write and start on the same edge: op sees the new value
        wr(0, 8'h01); wr(1, 8'h02);
        wr_en = 1'b1; wr_idx = 2'd0; wr_data = 8'h40; mdl_r[0] = 8'h40;
        do_op(OP_ADD, 0, 1, 1'b0, "wrstart");
        rd_idx = 2'd1; #1;
        check("wrstart_r1", 32'(rd_data), 32'h42);

        // Illegal opcode: error pulse, nothing else moves
        do_op(4'hC, 1, 2, 1'b0, "illegal_c");
        do_op(4'hF, 3, 0, 1'b0, "illegal_f");

        // Start held every cycle with changing opcodes, write attempted during EX2
        wr(0, 8'h10); wr(1, 8'h20);
        seq_ops[0] = OP_ADD; seq_ops[1] = OP_SUB; seq_ops[2] = OP_XOR; seq_ops[3] = OP_MOV;
        model_exec(OP_ADD, 0, 1);
        dcount = 0;
        for (int k = 0; k < 4; k++) begin
            start = 1'b1; opcode = seq_ops[k]; src = 2'(k); dest = 2'(3 - k);
            if (k == 0) begin src = 2'd0; dest = 2'd1; end
            wr_en = (k == 2); wr_idx = 2'd1; wr_data = 8'h77;
            tick();
            if (done) dcount++;
            if (k < 3) check($sformatf("busy_nodone_k%0d", k), 32'(done), 32'd0);
        end
        start = 1'b0; wr_en = 1'b0;
        check("busy_done_count", 32'(dcount), 32'd1);
        check("busy_done_now", 32'(done), 32'd1);
        rd_idx = 2'd1; #1;
        check("busy_r1", 32'(rd_data), 32'h30);
        check_model("busy");
        tick();
        check("busy_no_second", 32'(done), 32'd0);
        check("busy_ready", 32'(ready), 32'd1);

        // Reset while in EX2 of an ADD aborts the op
        do_reset();
        wr(2, 8'h05);
        start = 1'b1; opcode = OP_ADD; src = 2'd2; dest = 2'd1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        saw_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        check("abort_no_late_done", 32'(saw_done), 32'd0);
        check_model("abort");

        // Random ops with random register contents and bus noise while busy
        for (int n = 0; n < 60; n++) begin
            logic [3:0] rop;
            if ($urandom_range(2) == 0) wr(int'($urandom_range(3)), int'($urandom_range(255)));
            if ($urandom_range(2) == 0) wr(int'($urandom_range(3)), int'($urandom_range(255)));
            rop = ($urandom_range(5) == 0) ? 4'(8 + $urandom_range(7)) : 4'($urandom_range(7));
            do_op(rop, int'($urandom_range(3)), int'($urandom_range(3)), 1'b1, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
